loop_control: RTL and testbench
===============================

Name: loop_control

Overview:
- Sits directly upstream of the loop-select logic. It tracks the previously issued instruction and runs the iteration counter for LCG-type (repeat-in-place) instructions.
- Produces the two signals the loop-select stage consumes: `prev_instr`, the registered last-issued instruction, and `loop_cond`, the loop exit condition.
- The select stage re-issues the instruction from IR while `prev_instr` is LCG and `loop_cond` is 0. This block guarantees that happens exactly N times in total for a count of N.

Parameters:
- IW, 16, instruction width.
- OPC_W, 7, opcode field width; opcode = instr[OPC_W-1:0].
- LCG_OPC, 7'b0000100, LCG opcode value.
- CNT_W, 9, loop-count field width; count = instr[IW-1:OPC_W].

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- instr  in  IW  instruction being issued this cycle.
- instr_valid  in  1  instr is issued this cycle.
- stall  in  1  pipeline stall; freezes all state.
- flush  in  1  synchronous pipeline flush; aborts any loop.
- prev_instr  out  IW  registered last-issued instruction.
- loop_cond  out  1  1 = loop exit met / no loop pending; 0 = re-issue required.
- loop_active  out  1  high while in LOOPING.
- remaining  out  CNT_W  iterations still to issue after the current one.

Behaviour:
- Reset and flush (rst=1 or flush=1 at clk edge):
  - prev_instr=0, state=IDLE, remaining=0, loop_active=0, loop_cond=1.
  - rst has priority over flush.
  - flush has priority over stall and instr_valid.
- Issue qualification:
  - issue = instr_valid & ~stall.
  - With stall=1, all registers hold, even if instr_valid=1.
- prev_instr: on every issue, prev_instr <= instr at the next edge (1-cycle latency).
- Combinational outputs:
  - is_lcg = (instr[OPC_W-1:0] == LCG_OPC).
  - loop_cond = (state==IDLE) | (remaining==0). It is a pure function of registered state, with no combinational path from inputs.
  - loop_active = (state==LOOPING).
- State IDLE:
  - On issue with is_lcg, let N = count field. Set Neff = 1 if N==0, else N. Load remaining <= Neff-1.
  - If Neff>1, go to LOOPING; otherwise stay IDLE.
  - Non-LCG issue: only prev_instr updates.
- State LOOPING, issue of an LCG instruction (the re-issue from IR):
  - If remaining>1: remaining <= remaining-1.
  - If remaining==1: remaining <= 0 and go to IDLE.
  - The count field of the re-issued instruction is ignored while LOOPING.
- State LOOPING, issue of a non-LCG instruction (protocol violation): abort. Go to IDLE, remaining <= 0; prev_instr still updates.
- Timing of one loop: the instruction issues Neff times on consecutive non-stalled issue cycles. After the last issue, loop_cond=1 from the following cycle.
- Wrap rule: remaining never decrements below 0. N = 2^CNT_W-1 (511) must work with no overflow.
- Simultaneous events: flush wins over any issue in the same cycle. A stall during LOOPING holds remaining and state indefinitely.
- Reset mid-loop: next cycle IDLE, loop_cond=1, prev_instr=0. A 0 opcode is not LCG, so the select stage deasserts.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → prev_instr=0, loop_cond=1, loop_active=0, remaining=0.
- LCG with N=3 (instr=16'h0184), issued continuously:
  - Cycle after 1st issue: remaining=2, loop_cond=0.
  - Cycle after 2nd issue: remaining=1, loop_cond=0.
  - Cycle after 3rd issue: IDLE, loop_cond=1.
  - Exactly 3 issues total.
- LCG with N=0 and with N=1 → single issue; loop_cond stays 1; loop_active never asserts.
- LCG N=4 with stall=1 for 5 cycles after the 2nd issue → remaining holds at 2 throughout the stall. Loop completes after 2 more issues once the stall drops.
- Flush mid-loop (N=5, flush after 2nd issue, instr_valid=1 in the same cycle) → next cycle IDLE, remaining=0, prev_instr=0, loop_cond=1.
- Non-LCG instr (opcode 7'b0000001) issued while LOOPING with remaining=3 → abort to IDLE, prev_instr=that instr, loop_cond=1.

Source files
------------

// File: rtl/loop_control.sv
// loop_control: tracks the last issued instruction and counts iterations of
// LCG (repeat-in-place) instructions for the downstream loop-select stage.
// The select stage re-issues from IR while prev_instr is LCG and loop_cond=0.
//
// Issue handshake: an instruction is accepted ("issued") on a rising edge
// exactly when instr_valid=1 and stall=0. With stall=1 nothing is accepted and
// every register holds, whatever instr_valid says. flush and rst override
// both and return the block to IDLE with prev_instr cleared.
module loop_control #(
   parameter int          IW      = 16,
   parameter int          OPC_W   = 7,
   parameter logic [6:0]  LCG_OPC = 7'b0000100,
   parameter int          CNT_W   = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IW-1:0]    instr,
   input  logic             instr_valid,
   input  logic             stall,
   input  logic             flush,
   output logic [IW-1:0]    prev_instr,
   output logic             loop_cond,
   output logic             loop_active,
   output logic [CNT_W-1:0] remaining
);

   typedef enum logic {
      IDLE    = 1'b0,
      LOOPING = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state, state_nxt;
   logic [CNT_W-1:0] remaining_nxt;
   logic [IW-1:0]    prev_nxt;
   logic             issue;
   logic             is_lcg;
   logic [CNT_W-1:0] cnt;

   assign issue  = instr_valid & ~stall;
   assign is_lcg = (instr[OPC_W-1:0] == LCG_OPC[OPC_W-1:0]);
   assign cnt    = instr[IW-1:OPC_W];

   // State register: reset/flush clear everything; otherwise take next values.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state      <= IDLE;
         remaining  <= '0;
         prev_instr <= '0;
      end else begin
         state      <= state_nxt;
         remaining  <= remaining_nxt;
         prev_instr <= prev_nxt;
      end
   end

   // Next-state logic: only an issue cycle changes anything.
   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      prev_nxt      = prev_instr;
      if (issue) begin
         prev_nxt = instr;
         case (state)
            IDLE: begin
               if (is_lcg) begin
                  // A count of 0 behaves like 1: one issue, no looping.
                  remaining_nxt = (cnt == '0) ? '0 : cnt - ONE;
                  state_nxt     = (cnt > ONE) ? LOOPING : IDLE;
               end
            end
            LOOPING: begin
               if (is_lcg) begin
                  // Count field of the re-issued copy is ignored here.
                  if (remaining > ONE) begin
                     remaining_nxt = remaining - ONE;
                  end else begin
                     remaining_nxt = '0;
                     state_nxt     = IDLE;
                  end
               end else begin
                  // Anything other than the LCG re-issue aborts the loop.
                  remaining_nxt = '0;
                  state_nxt     = IDLE;
               end
            end
            default: begin
               state_nxt     = IDLE;
               remaining_nxt = '0;
            end
         endcase
      end
   end

   // Outputs: pure functions of registered state, no input-to-output path.
   always_comb begin
      loop_active = (state == LOOPING);
      loop_cond   = (state == IDLE) | (remaining == '0);
   end

endmodule

// File: tb/tb_loop_control.sv
// Self-checking bench for loop_control: a reference model pushes the expected
// output vector each driven cycle and it is compared after the clock edge,
// plus directed checks for the loop scenarios and their boundaries.
module tb_loop_control;

   localparam int         IW    = 16;
   localparam int         OPC_W = 7;
   localparam int         CNT_W = 9;
   localparam logic [6:0] LCG   = 7'b0000100;
   localparam int         SW    = IW + 2 + CNT_W;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             instr_valid = 1'b0;
   logic             stall = 1'b0;
   logic [IW-1:0]    instr = '0;
   logic [IW-1:0]    prev_instr;
   logic             loop_cond;
   logic             loop_active;
   logic [CNT_W-1:0] remaining;

   int checks = 0;
   int errors = 0;

   logic [SW-1:0] exp_q[$];

   // reference model state
   logic [IW-1:0] m_prev = '0;
   int            m_rem  = 0;
   bit            m_loop = 1'b0;

   loop_control dut (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr),
      .instr_valid (instr_valid),
      .stall       (stall),
      .flush       (flush),
      .prev_instr  (prev_instr),
      .loop_cond   (loop_cond),
      .loop_active (loop_active),
      .remaining   (remaining)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [IW-1:0] lcg(input int n);
      logic [CNT_W-1:0] c;
      c = n[CNT_W-1:0];
      return {c, LCG};
   endfunction

   task automatic model_step(input logic r, input logic f, input logic [IW-1:0] i,
                             input logic v, input logic s);
      int n;
      bit l;
      if (r || f) begin
         m_prev = '0;
         m_rem  = 0;
         m_loop = 1'b0;
      end else if (v && !s) begin
         l = (i[OPC_W-1:0] == LCG);
         n = int'(i[IW-1:OPC_W]);
         if (!m_loop) begin
            if (l) begin
               m_rem  = (n == 0) ? 0 : n - 1;
               m_loop = (m_rem > 0);
            end
         end else if (l) begin
            m_rem  = m_rem - 1;
            m_loop = (m_rem > 0);
         end else begin
            m_rem  = 0;
            m_loop = 1'b0;
         end
         m_prev = i;
      end
   endtask

   // one clock of stimulus, model update and scoreboard compare
   task automatic drive(input logic r, input logic f, input logic [IW-1:0] i,
                        input logic v, input logic s);
      logic [SW-1:0]    e;
      logic [CNT_W-1:0] mr;
      @(negedge clk);
      rst = r; flush = f; instr = i; instr_valid = v; stall = s;
      model_step(r, f, i, v, s);
      mr = m_rem[CNT_W-1:0];
      exp_q.push_back({m_prev, ~m_loop, m_loop, mr});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("sb", {prev_instr, loop_cond, loop_active, remaining}, e);
      end
   endtask

   task automatic issue(input logic [IW-1:0] i);
      drive(1'b0, 1'b0, i, 1'b1, 1'b0);
   endtask

   // acts as the select stage: re-issue while prev is LCG and loop_cond=0
   task automatic run_loop(input logic [IW-1:0] i, output int n, output bit seen_active);
      n = 0;
      seen_active = 1'b0;
      issue(i);
      n++;
      seen_active |= loop_active;
      while (prev_instr[OPC_W-1:0] == LCG && !loop_cond && n < 600) begin
         issue(i);
         n++;
         seen_active |= loop_active;
      end
   endtask

   initial begin
      int  n;
      bit  act;
      logic [IW-1:0] ri;

      // reset
      drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
      check("rst_prev", prev_instr, 32'h0);
      check("rst_cond", loop_cond, 32'd1);
      check("rst_active", loop_active, 32'd0);
      check("rst_rem", remaining, 32'd0);
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);

      // N=3 continuous
      issue(16'h0184);
      check("n3_rem1", remaining, 32'd2);
      check("n3_cond1", loop_cond, 32'd0);
      issue(16'h0184);
      check("n3_rem2", remaining, 32'd1);
      check("n3_cond2", loop_cond, 32'd0);
      issue(16'h0184);
      check("n3_cond3", loop_cond, 32'd1);
      check("n3_idle", loop_active, 32'd0);
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
      run_loop(16'h0184, n, act);
      check("n3_issues", n, 32'd3);

      // N=0 and N=1: single issue, never active
      run_loop(lcg(0), n, act);
      check("n0_issues", n, 32'd1);
      check("n0_active", act, 32'd0);
      check("n0_cond", loop_cond, 32'd1);
      run_loop(lcg(1), n, act);
      check("n1_issues", n, 32'd1);
      check("n1_active", act, 32'd0);
      check("n1_cond", loop_cond, 32'd1);

      // N=4 with a 5-cycle stall after the 2nd issue
      issue(lcg(4));
      issue(lcg(4));
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b0, lcg(4), 1'b1, 1'b1);
         check("stall_rem", remaining, 32'd2);
         check("stall_active", loop_active, 32'd1);
      end
      issue(lcg(4));
      check("stall_rem3", remaining, 32'd1);
      issue(lcg(4));
      check("stall_done", loop_cond, 32'd1);
      check("stall_rem4", remaining, 32'd0);

      // flush mid-loop with instr_valid in the same cycle
      issue(lcg(5));
      issue(lcg(5));
      drive(1'b0, 1'b1, lcg(5), 1'b1, 1'b0);
      check("flush_rem", remaining, 32'd0);
      check("flush_prev", prev_instr, 32'h0);
      check("flush_cond", loop_cond, 32'd1);
      check("flush_active", loop_active, 32'd0);

      // non-LCG during LOOPING aborts
      issue(lcg(5));
      issue(lcg(5));
      check("abort_pre_rem", remaining, 32'd3);
      issue(16'h0001);
      check("abort_prev", prev_instr, 32'h0001);
      check("abort_cond", loop_cond, 32'd1);
      check("abort_active", loop_active, 32'd0);
      check("abort_rem", remaining, 32'd0);

      // maximum count
      issue(lcg(511));
      check("max_rem", remaining, 32'd510);
      n = 1;
      while (!loop_cond && n < 600) begin
         issue(lcg(511));
         n++;
      end
      check("max_issues", n, 32'd511);
      check("max_cond", loop_cond, 32'd1);

      // reset mid-loop
      issue(lcg(6));
      drive(1'b1, 1'b0, lcg(6), 1'b1, 1'b0);
      check("rstmid_prev", prev_instr, 32'h0);
      check("rstmid_cond", loop_cond, 32'd1);

      // random traffic against the model
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 1) == 1) begin
            ri = lcg($urandom_range(0, 6));
         end else begin
            ri = IW'($urandom);
            if (ri[OPC_W-1:0] == LCG) ri[0] = 1'b1;
         end
         drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3, ri,
               $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
